// File: rtl/rhd_spi_responder.sv
// rhd_spi_responder: emulates the SPI slave side of one Intan RHD2000 chip for loopback testing.
// Ports:
//   clk, rstn          system clock, synchronous active-low reset
//   CS, SCLK, MOSI     asynchronous SPI inputs from the master (CS active-low, SCLK idle low)
//   MISO               response bits; the response to frame N is sent during frame N+2
//   cmd_valid          one-cycle pulse per well-formed 16-bit frame
//   last_cmd           most recent well-formed command
//   frame_error        sticky flag set when CS rises with a bit count other than 16
module rhd_spi_responder #(
    parameter logic [7:0] CHIP_ID = 8'd1,
    parameter bit         DDR     = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] last_cmd,
    output logic        frame_error
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

    // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0]  cs_sync_q, sclk_sync_q;
    logic [1:0]  mosi_sync_q;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_sr_q, rx_sr_d, tx_a_q, tx_a_d, tx_b_q, tx_b_d;
    logic [15:0] last_cmd_q, last_cmd_d;
    logic [31:0] st1_q, st1_d, st2_q, st2_d;
    logic [9:0]  samp_cnt_q, samp_cnt_d, sweep_q, sweep_d;
    logic        pend_q, pend_d, miso_q, miso_d, cmd_valid_q, cmd_valid_d;
    logic        frame_error_q, frame_error_d;
    logic [7:0]  regs_q [0:17];
    logic [7:0]  regs_d [0:17];

    logic        cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  data, rd_val;
    logic [15:0] conv_w;
    logic [31:0] resp;

    assign cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
    assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
    assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];

    assign op   = rx_sr_q[15:14];
    assign addr = rx_sr_q[13:8];
    assign data = rx_sr_q[7:0];

    always_comb begin
        rd_val = 8'h00;
        if (addr <= 6'd17)
            rd_val = regs_q[addr[4:0]];
        else
            case (addr)
                6'd40:   rd_val = 8'h49;
                6'd41:   rd_val = 8'h4E;
                6'd42:   rd_val = 8'h54;
                6'd43:   rd_val = 8'h41;
                6'd44:   rd_val = 8'h4E;
                6'd61:   rd_val = 8'h01;
                6'd62:   rd_val = 8'h20;
                6'd63:   rd_val = CHIP_ID;
                default: rd_val = 8'h00;
            endcase
    end

    // Channel 0 opens a sweep: it reports the live sample count and latches it
    // so the remaining channels of that sweep report the same sample number.
    assign conv_w = {addr, addr == 6'd0 ? samp_cnt_q : sweep_q};
    assign resp   = op == 2'b00 ? (addr[5] ? 32'd0 : {conv_w, ~conv_w}) :
                    op == 2'b01 ? 32'd0 :
                    op == 2'b10 ? {2{8'hFF, data}} : {2{8'h00, rd_val}};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        tx_a_d        = tx_a_q;
        tx_b_d        = tx_b_q;
        last_cmd_d    = last_cmd_q;
        st1_d         = st1_q;
        st2_d         = st2_q;
        samp_cnt_d    = samp_cnt_q;
        sweep_d       = sweep_q;
        pend_d        = pend_q;
        miso_d        = miso_q;
        cmd_valid_d   = 1'b0;
        frame_error_d = frame_error_q;
        regs_d        = regs_q;
        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall || pend_q) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = 5'd0;
                    tx_a_d    = st2_q[31:16];
                    tx_b_d    = st2_q[15:0];
                    miso_d    = st2_q[31];
                    pend_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_END;
                    miso_d  = 1'b0;
                    if (bit_cnt_q == 5'd16) begin
                        st1_d       = resp;
                        st2_d       = st1_q;
                        cmd_valid_d = 1'b1;
                        last_cmd_d  = rx_sr_q;
                        if (op == 2'b10 && addr <= 6'd17)
                            regs_d[addr[4:0]] = data;
                        if (op == 2'b00 && addr == 6'd0) begin
                            samp_cnt_d = samp_cnt_q + 10'd1;
                            sweep_d    = samp_cnt_q;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_sr_d   = {rx_sr_q[14:0], mosi_sync_q[1]};
                    bit_cnt_d = bit_cnt_q == 5'd31 ? bit_cnt_q : bit_cnt_q + 5'd1;
                    if (DDR)
                        miso_d = bit_cnt_q[4] ? 1'b0 : tx_b_q[~bit_cnt_q[3:0]];
                end else if (sclk_fall) begin
                    // bit_cnt already counts this bit's rise, so 15-bit_cnt selects the next A bit
                    miso_d = bit_cnt_q == 5'd16 ? tx_a_q[0] :
                             bit_cnt_q[4] ? 1'b0 : tx_a_q[~bit_cnt_q[3:0]];
                end
            end
            default: begin
                state_d = S_IDLE;
                // a CS fall seen here would be lost by the edge detector, so hold it for IDLE
                if (cs_fall)
                    pend_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // synchronizers reset low so a CS already low at reset release is not seen as a new frame
            cs_sync_q     <= '0;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            rx_sr_q       <= '0;
            tx_a_q        <= '0;
            tx_b_q        <= '0;
            last_cmd_q    <= '0;
            st1_q         <= '0;
            st2_q         <= '0;
            samp_cnt_q    <= '0;
            sweep_q       <= '0;
            pend_q        <= 1'b0;
            miso_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < 18; i++)
                regs_q[i] <= '0;
        end else begin
            cs_sync_q     <= {cs_sync_q[1:0], CS};
            sclk_sync_q   <= {sclk_sync_q[1:0], SCLK};
            mosi_sync_q   <= {mosi_sync_q[0], MOSI};
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_a_q        <= tx_a_d;
            tx_b_q        <= tx_b_d;
            last_cmd_q    <= last_cmd_d;
            st1_q         <= st1_d;
            st2_q         <= st2_d;
            samp_cnt_q    <= samp_cnt_d;
            sweep_q       <= sweep_d;
            pend_q        <= pend_d;
            miso_q        <= miso_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_error_q <= frame_error_d;
            regs_q        <= regs_d;
        end
    end

    assign MISO        = miso_q;
    assign cmd_valid   = cmd_valid_q;
    assign last_cmd    = last_cmd_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_rhd_spi_responder.sv
// tb_rhd_spi_responder: directed vector bench for rhd_spi_responder acting as an SPI master.
module tb_rhd_spi_responder;
    logic        clk = 1'b0;
    logic        rstn, CS, SCLK, MOSI;
    logic        MISO, cmd_valid, frame_error;
    logic [15:0] last_cmd;
    int          checks = 0;
    int          errors = 0;

    rhd_spi_responder #(.CHIP_ID(8'd1), .DDR(1'b1)) dut (
        .clk(clk), .rstn(rstn), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .cmd_valid(cmd_valid), .last_cmd(last_cmd), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI frame; SCLK half period is 6 clk. A bits are sampled before each
    // rise, B bits after it. rst_at >= 0 pulses rstn at the start of that bit.
    task automatic frame(input logic [15:0] cmd, input int nbits, input int rst_at,
                         output logic [15:0] a, output logic [15:0] b, output int nvalid);
        a = '0;
        b = '0;
        nvalid = 0;
        CS = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                rstn = 1'b0;
                repeat (4) @(negedge clk);
                chk("rst_miso", {31'd0, MISO}, 32'd0);
                chk("rst_ferr", {31'd0, frame_error}, 32'd0);
                rstn = 1'b1;
            end
            MOSI = (k < 16) ? cmd[15-k] : 1'b0;
            repeat (6) @(negedge clk);
            if (k < 16) a[15-k] = MISO;
            SCLK = 1'b1;
            repeat (6) @(negedge clk);
            if (k < 16) b[15-k] = MISO;
            SCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
        CS = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) nvalid++;
        end
    endtask

    initial begin
        logic [15:0] a, b;
        int nv;
        vecs[0]  = '{16'hFF00, 16'h0000, 16'h0000};
        vecs[1]  = '{16'hE800, 16'h0000, 16'h0000};
        vecs[2]  = '{16'hE900, 16'h0001, 16'h0001};
        vecs[3]  = '{16'h85A7, 16'h0049, 16'h0049};
        vecs[4]  = '{16'hC500, 16'h004E, 16'h004E};
        vecs[5]  = '{16'h0000, 16'hFFA7, 16'hFFA7};
        vecs[6]  = '{16'h0100, 16'h00A7, 16'h00A7};
        vecs[7]  = '{16'h0000, 16'h0000, 16'hFFFF};
        vecs[8]  = '{16'h0100, 16'h0400, 16'hFBFF};
        vecs[9]  = '{16'h2800, 16'h0001, 16'hFFFE};
        vecs[10] = '{16'h5500, 16'h0401, 16'hFBFE};
        vecs[11] = '{16'hB23C, 16'h0000, 16'h0000};
        vecs[12] = '{16'hF200, 16'h0000, 16'h0000};
        vecs[13] = '{16'h6A00, 16'hFF3C, 16'hFF3C};
        vecs[14] = '{16'hFE00, 16'h0000, 16'h0000};
        vecs[15] = '{16'hFD00, 16'h0000, 16'h0000};
        vecs[16] = '{16'hEC00, 16'h0020, 16'h0020};
        vecs[17] = '{16'hD100, 16'h0001, 16'h0001};
        vecs[18] = '{16'hFF00, 16'h004E, 16'h004E};
        vecs[19] = '{16'hFF00, 16'h0000, 16'h0000};

        rstn = 1'b0;
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_miso", {31'd0, MISO}, 32'd0);
        chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("reset_last_cmd", {16'd0, last_cmd}, 32'd0);
        chk("reset_frame_error", {31'd0, frame_error}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_miso", {31'd0, MISO}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            frame(vecs[i].cmd, 16, -1, a, b, nv);
            chk($sformatf("v%0d_a", i), {16'd0, a}, {16'd0, vecs[i].exp_a});
            chk($sformatf("v%0d_b", i), {16'd0, b}, {16'd0, vecs[i].exp_b});
            chk($sformatf("v%0d_valid", i), nv, 32'd1);
            chk($sformatf("v%0d_last_cmd", i), {16'd0, last_cmd}, {16'd0, vecs[i].cmd});
        end
        chk("table_frame_error", {31'd0, frame_error}, 32'd0);

        // short frame must not disturb the pipeline
        frame(16'hE800, 16, -1, a, b, nv);
        frame(16'hE900, 16, -1, a, b, nv);
        frame(16'hFF00, 15, -1, a, b, nv);
        chk("short_valid", nv, 32'd0);
        chk("short_frame_error", {31'd0, frame_error}, 32'd1);
        chk("short_last_cmd", {16'd0, last_cmd}, 32'hE900);
        frame(16'hFD00, 16, -1, a, b, nv);
        chk("post_err1_a", {16'd0, a}, 32'h0049);
        chk("post_err1_valid", nv, 32'd1);
        frame(16'hFD00, 16, -1, a, b, nv);
        chk("post_err2_a", {16'd0, a}, 32'h004E);
        chk("sticky_frame_error", {31'd0, frame_error}, 32'd1);

        // reset in the middle of a frame
        frame(16'hFF00, 16, 8, a, b, nv);
        chk("midrst_valid", nv, 32'd0);
        chk("midrst_frame_error", {31'd0, frame_error}, 32'd0);
        chk("midrst_last_cmd", {16'd0, last_cmd}, 32'd0);
        frame(16'hC500, 16, -1, a, b, nv);
        chk("after_rst1_a", {16'd0, a}, 32'h0000);
        chk("after_rst1_valid", nv, 32'd1);
        frame(16'hE800, 16, -1, a, b, nv);
        chk("after_rst2_a", {16'd0, a}, 32'h0000);
        frame(16'hFF00, 16, -1, a, b, nv);
        chk("after_rst3_reg5", {16'd0, a}, 32'h0000);
        frame(16'hFF00, 16, -1, a, b, nv);
        chk("after_rst4_a", {16'd0, a}, 32'h0049);
        chk("after_rst4_b", {16'd0, b}, 32'h0049);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
